camera_bringup: RTL and testbench

Upstream sequencer for the camera register loader. Drives the camera power-down and reset pins through the datasheet power-up timing. Issues the init_valid/init_ready handshake that starts the BRAM-to-SCCB register load, then waits for the loader to return to idle. Reports camera ready, retries the whole sequence on timeout, and latches an error after MAX_RETRIES failures.

---
 rtl/camera_pkg.sv | 39 +++
 rtl/camera_bringup_if.sv | 9 +
 rtl/cycle_timer.sv | 29 ++
 rtl/camera_bringup.sv | 143 ++++++++++++++
 tb/tb_camera_bringup.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/camera_pkg.sv
// Shared state type, default 100 MHz timing and small helpers for the
// camera bring-up sequencer.
package camera_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    PWDN       = 4'd1,
    RESET      = 4'd2,
    SETTLE     = 4'd3,
    REQ_CFG    = 4'd4,
    WAIT_START = 4'd5,
    WAIT_DONE  = 4'd6,
    READY      = 4'd7,
    ERROR      = 4'd8
  } bringup_state_t;

  // Datasheet power-up timing at 100 MHz: 1 ms, 1 ms, 20 ms; 500 ms load budget.
  localparam int DEF_PWDN_CYCLES   = 100_000;
  localparam int DEF_RST_CYCLES    = 100_000;
  localparam int DEF_SETTLE_CYCLES = 2_000_000;
  localparam int DEF_CFG_TIMEOUT   = 50_000_000;
  localparam int DEF_MAX_RETRIES   = 3;

  // Largest of the four cycle counts; sizes the shared counters.
  function automatic int max_cycles(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // States during which the configuration timeout is running.
  function automatic logic in_cfg_phase(input bringup_state_t s);
    return (s == REQ_CFG) || (s == WAIT_START) || (s == WAIT_DONE);
  endfunction

endpackage

// File: rtl/camera_bringup_if.sv
// Load-request handshake between the bring-up sequencer (master) and the
// BRAM-to-SCCB register loader (slave).
interface camera_bringup_if;
  logic init_valid;
  logic init_ready;

  modport master (output init_valid, input init_ready);
  modport slave  (input init_valid, output init_ready);
endinterface

// File: rtl/cycle_timer.sv
// Up-counter with synchronous clear, used for the per-state timer and the
// configuration timeout counter.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: restart at zero on clear, otherwise advance by one.
  always_comb begin
    count_d = count_q + 1'b1;
    if (clear_in) count_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/camera_bringup.sv
// Camera power-up sequencer: walks PWDN/RESETB through the datasheet timing,
// requests the register load, waits for the loader to finish, and retries
// with a full power cycle on timeout until the retry budget is spent.
module camera_bringup
  import camera_pkg::*;
#(
  parameter int PWDN_CYCLES   = DEF_PWDN_CYCLES,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CFG_TIMEOUT   = DEF_CFG_TIMEOUT,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  camera_bringup_if.master        init_if,
  output logic                    cam_pwdn_out,
  output logic                    cam_rst_n_out,
  output logic                    cam_ready_out,
  output logic                    busy_out,
  output logic                    error_out,
  output logic [7:0]              retries_out
);

  localparam int TIMER_W = $clog2(max_cycles(PWDN_CYCLES, RST_CYCLES,
                                             SETTLE_CYCLES, CFG_TIMEOUT)) + 1;
  localparam logic [TIMER_W-1:0] PWDN_LAST   = TIMER_W'(PWDN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CFG_LAST    = TIMER_W'(CFG_TIMEOUT - 1);
  localparam logic [7:0]         RETRY_LIMIT = 8'(MAX_RETRIES);

  bringup_state_t     state_q, state_d;
  logic [7:0]         retries_q, retries_d;
  logic [TIMER_W-1:0] timer_cnt, cfg_cnt;
  logic               timer_clear, cfg_clear;
  logic               cfg_done, cfg_expired;
  logic               valid_o;

  // State timer restarts on every state change; the cfg counter spans the
  // whole request/load window and only restarts on entry to REQ_CFG.
  assign timer_clear = (state_d != state_q);
  assign cfg_clear   = !in_cfg_phase(state_d) ||
                       ((state_d == REQ_CFG) && (state_q != REQ_CFG));

  cycle_timer #(.WIDTH(TIMER_W)) u_state_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (timer_clear),
    .count_out(timer_cnt)
  );

  cycle_timer #(.WIDTH(TIMER_W)) u_cfg_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (cfg_clear),
    .count_out(cfg_cnt)
  );

  // Load completion beats a timeout landing on the same edge.
  assign cfg_done    = (state_q == WAIT_DONE) && init_if.init_ready;
  assign cfg_expired = in_cfg_phase(state_q) && (cfg_cnt == CFG_LAST) && !cfg_done;

  // Next-state and retry bookkeeping.
  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    case (state_q)
      IDLE, READY, ERROR: begin
        if (start_in) begin
          state_d   = PWDN;
          retries_d = '0;
        end
      end
      PWDN:       if (timer_cnt == PWDN_LAST)   state_d = RESET;
      RESET:      if (timer_cnt == RST_LAST)    state_d = SETTLE;
      SETTLE:     if (timer_cnt == SETTLE_LAST) state_d = REQ_CFG;
      REQ_CFG:    if (init_if.init_ready)       state_d = WAIT_START;
      WAIT_START: if (!init_if.init_ready)      state_d = WAIT_DONE;
      WAIT_DONE:  if (init_if.init_ready)       state_d = READY;
      default:    state_d = IDLE;
    endcase
    if (cfg_expired) begin
      retries_d = retries_q + 8'd1;
      state_d   = (retries_d == RETRY_LIMIT) ? ERROR : PWDN;
    end
  end

  // State and retry registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      retries_q <= retries_d;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    cam_pwdn_out  = 1'b0;
    cam_rst_n_out = 1'b1;
    valid_o       = 1'b0;
    cam_ready_out = 1'b0;
    busy_out      = 1'b0;
    error_out     = 1'b0;
    case (state_q)
      IDLE: begin
        cam_pwdn_out  = 1'b1;
        cam_rst_n_out = 1'b0;
      end
      PWDN: begin
        cam_pwdn_out  = 1'b1;
        cam_rst_n_out = 1'b0;
        busy_out      = 1'b1;
      end
      RESET: begin
        cam_rst_n_out = 1'b0;
        busy_out      = 1'b1;
      end
      SETTLE, WAIT_START, WAIT_DONE: busy_out = 1'b1;
      REQ_CFG: begin
        valid_o  = 1'b1;
        busy_out = 1'b1;
      end
      READY: cam_ready_out = 1'b1;
      ERROR: begin
        cam_pwdn_out  = 1'b1;
        cam_rst_n_out = 1'b0;
        error_out     = 1'b1;
      end
      default: begin
        cam_pwdn_out  = 1'b1;
        cam_rst_n_out = 1'b0;
      end
    endcase
  end

  assign init_if.init_valid = valid_o;
  assign retries_out        = retries_q;

endmodule

// File: tb/tb_camera_bringup.sv
// Self-checking bench for camera_bringup: a loader model answers the load
// handshake, and expected event times are derived from the timing rules.
module tb_camera_bringup;

  localparam int P  = 4;
  localparam int R  = 3;
  localparam int S  = 5;
  localparam int T  = 40;
  localparam int MR = 2;
  localparam int V  = P + R + S;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       start_in;
  logic       cam_pwdn_out, cam_rst_n_out, cam_ready_out, busy_out, error_out;
  logic [7:0] retries_out;

  camera_bringup_if init_if ();

  camera_bringup #(
    .PWDN_CYCLES  (P),
    .RST_CYCLES   (R),
    .SETTLE_CYCLES(S),
    .CFG_TIMEOUT  (T),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .init_if      (init_if),
    .cam_pwdn_out (cam_pwdn_out),
    .cam_rst_n_out(cam_rst_n_out),
    .cam_ready_out(cam_ready_out),
    .busy_out     (busy_out),
    .error_out    (error_out),
    .retries_out  (retries_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Observations from the most recent sequence, cycle 0 = first PWDN cycle.
  int s0_retries, s0_error, s0_pwdn, s0_rstn;
  int t_pwdn_fall, t_rstn_rise, t_valid_rise, t_ready_rise, t_retry1, t_err_rise;
  int valid_cnt, busy_cnt;
  int r1_pwdn, r1_busy, e_retries, e_pwdn, e_rstn, e_busy;

  task automatic check_value(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Start a sequence and run ncyc cycles while the loader model answers.
  // hold: cycles the loader stays busy once init_valid is seen;
  // load: cycles init_ready stays low after the handshake;
  // stuck: the loader never comes back after the handshake;
  // kick_at: cycle at which a stray start_in pulse is injected (-1 = none).
  task automatic run_seq(input int hold, input int load, input bit stuck,
                         input int kick_at, input int ncyc);
    int hold_left;
    int busy_left;
    bit dead;
    bit hs;
    bit v;
    hold_left = hold;
    busy_left = 0;
    dead      = 1'b0;
    t_pwdn_fall = -1; t_rstn_rise = -1; t_valid_rise = -1;
    t_ready_rise = -1; t_retry1 = -1; t_err_rise = -1;
    valid_cnt = 0; busy_cnt = 0;
    r1_pwdn = -1; r1_busy = -1; e_retries = -1; e_pwdn = -1; e_rstn = -1; e_busy = -1;
    init_if.init_ready = (hold_left == 0);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      init_if.init_ready = (hold_left == 0) && (busy_left == 0) && !dead;
      start_in = (t == kick_at);
      if (t == 0) begin
        s0_retries = int'(retries_out);
        s0_error   = int'(error_out);
        s0_pwdn    = int'(cam_pwdn_out);
        s0_rstn    = int'(cam_rst_n_out);
      end
      if (t_pwdn_fall < 0 && !cam_pwdn_out) t_pwdn_fall = t;
      if (t_rstn_rise < 0 && cam_rst_n_out) t_rstn_rise = t;
      if (t_valid_rise < 0 && init_if.init_valid) t_valid_rise = t;
      if (init_if.init_valid) valid_cnt++;
      if (busy_out) busy_cnt++;
      if (t_ready_rise < 0 && cam_ready_out) t_ready_rise = t;
      if (t_retry1 < 0 && retries_out == 8'd1) begin
        t_retry1 = t;
        r1_pwdn  = int'(cam_pwdn_out);
        r1_busy  = int'(busy_out);
      end
      if (t_err_rise < 0 && error_out) begin
        t_err_rise = t;
        e_retries  = int'(retries_out);
        e_pwdn     = int'(cam_pwdn_out);
        e_rstn     = int'(cam_rst_n_out);
        e_busy     = int'(busy_out);
      end
      v  = init_if.init_valid;
      hs = init_if.init_valid && init_if.init_ready;
      step();
      if (hs) begin
        if (stuck) dead = 1'b1;
        else       busy_left = load;
      end else begin
        if (busy_left > 0) busy_left--;
        if (v && hold_left > 0) hold_left--;
      end
    end
    start_in = 1'b0;
    init_if.init_ready = !dead;
  endtask

  // A successful bring-up: all event times follow from the cycle counts.
  task automatic expect_success(input int hold, input int load, input int kick);
    run_seq(hold, load, 1'b0, kick, V + hold + load + 8);
    $display("run hold=%0d load=%0d kick=%0d ready_at=%0d retries0=%0d",
             hold, load, kick, t_ready_rise, s0_retries);
    check_value("start_retries", s0_retries, 0);
    check_value("start_error", s0_error, 0);
    check_value("start_pwdn", s0_pwdn, 1);
    check_value("start_rstn", s0_rstn, 0);
    check_value("pwdn_fall", t_pwdn_fall, P);
    check_value("rstn_rise", t_rstn_rise, P + R);
    check_value("valid_rise", t_valid_rise, V);
    check_value("valid_len", valid_cnt, hold + 1);
    check_value("ready_rise", t_ready_rise, V + hold + load + 2);
    check_value("busy_len", busy_cnt, V + hold + load + 2);
    check_value("no_error", t_err_rise, -1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_pwdn"}, int'(cam_pwdn_out), 1);
    check_value({tag, "_rstn"}, int'(cam_rst_n_out), 0);
    check_value({tag, "_valid"}, int'(init_if.init_valid), 0);
    check_value({tag, "_ready"}, int'(cam_ready_out), 0);
    check_value({tag, "_busy"}, int'(busy_out), 0);
    check_value({tag, "_error"}, int'(error_out), 0);
    check_value({tag, "_retries"}, int'(retries_out), 0);
  endtask

  initial begin
    int h, l, k;
    rst_in   = 1'b1;
    start_in = 1'b0;
    init_if.init_ready = 1'b1;

    // Reset asserted before any clock edge.
    #1 rst_in = 1'b0;
    #1;
    $display("reset asserted, no clock edge yet");
    check_idle_outputs("rst");
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    repeat (10) step();
    $display("after reset release and 10 idle cycles");
    check_idle_outputs("idle");

    // Basic bring-up with a 10-cycle load, then a loader that is busy 6 cycles.
    expect_success(0, 10, -1);
    expect_success(6, $urandom_range(1, 10), -1);

    // Randomized loader behaviour, sometimes with a stray start during SETTLE.
    for (int i = 0; i < 6; i++) begin
      h = $urandom_range(0, 6);
      l = $urandom_range(1, 10);
      k = ($urandom_range(0, 1) == 1) ? (P + R + $urandom_range(0, S - 1)) : -1;
      expect_success(h, l, k);
    end

    // Completion on the very edge the timeout would fire.
    expect_success(T - 12, 10, -1);

    // Loader never returns: two timeouts, second one latches the error.
    run_seq(0, 0, 1'b1, -1, 2 * V + 2 * T + 6);
    $display("run stuck retry1_at=%0d error_at=%0d error_retries=%0d",
             t_retry1, t_err_rise, e_retries);
    check_value("stuck_valid_rise", t_valid_rise, V);
    check_value("retry1_time", t_retry1, V + T);
    check_value("retry1_pwdn", r1_pwdn, 1);
    check_value("retry1_busy", r1_busy, 1);
    check_value("stuck_valid_len", valid_cnt, 1 + T);
    check_value("error_time", t_err_rise, 2 * V + 2 * T);
    check_value("error_retries", e_retries, MR);
    check_value("error_pwdn", e_pwdn, 1);
    check_value("error_rstn", e_rstn, 0);
    check_value("error_busy", e_busy, 0);
    check_value("stuck_no_ready", t_ready_rise, -1);
    check_value("error_held", int'(error_out), 1);

    // Restart from ERROR, with a stray start during SETTLE.
    expect_success(2, 3, P + R + 1);

    // Asynchronous reset in the middle of WAIT_DONE.
    run_seq(0, 10, 1'b0, -1, V + 5);
    #2 rst_in = 1'b0;
    #1;
    $display("reset asserted mid load");
    check_idle_outputs("midrst");
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    init_if.init_ready = 1'b1;
    repeat (3) step();
    check_idle_outputs("postrst");
    expect_success(0, 5, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
